mux_scan_sequencer: RTL and testbench

//  Upstream controller for the 8:1 single-bit mux. Steps the mux select lines
//  {S2,S1,S0} through all eight codes and samples the mux output after a

---
 rtl/mux_scan_sequencer_if.sv | 25 ++
 rtl/mux_scan_sequencer.sv | 98 +++++++++
 tb/tb_mux_scan_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_if.sv
// Handshake bundle between the mux scan sequencer (master) and the unit that
// requests scans and consumes the assembled byte (slave).
interface mux_scan_sequencer_if;
  logic       start;
  logic       ready;
  logic       busy;
  logic       valid;
  logic [7:0] data;

  modport master (
    input  start,
    input  ready,
    output busy,
    output valid,
    output data
  );

  modport slave (
    output start,
    output ready,
    input  busy,
    input  valid,
    input  data
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps an 8:1 mux select through all codes, samples its output after a
// programmable settle time and hands the assembled byte out on valid/ready.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE  = 1,
  parameter bit          DESCEND = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mux_o,
  output logic                  S0,
  output logic                  S1,
  output logic                  S2,
  mux_scan_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_C   = 4'(SETTLE);
  localparam logic [2:0] FIRST_CODE = DESCEND ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_CODE  = DESCEND ? 3'd0 : 3'd7;
  // With no settle time every code is sampled on the cycle after it is driven.
  localparam state_t     SCAN_ENTRY = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t     state_q;
  logic [2:0] idx_q;
  logic [3:0] cnt_q;
  logic [7:0] data_q;
  logic       busy_q;
  logic       valid_q;
  logic [2:0] idx_d;

  assign idx_d = DESCEND ? (idx_q - 3'd1) : (idx_q + 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            idx_q   <= FIRST_CODE;
            cnt_q   <= SETTLE_C;
            busy_q  <= 1'b1;
            state_q <= SCAN_ENTRY;
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          data_q[idx_q] <= mux_o;
          if (idx_q == LAST_CODE) begin
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end else begin
            idx_q   <= idx_d;
            cnt_q   <= SETTLE_C;
            state_q <= SCAN_ENTRY;
          end
        end
        ST_HOLD: begin
          // start is deliberately not looked at here, even on the accept edge.
          if (bus.ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign S0        = idx_q[0];
  assign S1        = idx_q[1];
  assign S2        = idx_q[2];
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.data  = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: two sequencers (ascending/settle 1, descending/settle 0)
// scanning bench-modelled muxes, checked against a timeline reference model.
module tb_mux_scan_sequencer;

  localparam int SA = 1;
  localparam int SB = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_scan_sequencer_if bus_a ();
  mux_scan_sequencer_if bus_b ();

  logic       mux_a, mux_b;
  logic       a_s0, a_s1, a_s2, b_s0, b_s1, b_s2;
  logic [7:0] pat_a, pat_b;

  mux_scan_sequencer #(.SETTLE(SA), .DESCEND(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .mux_o(mux_a),
    .S0(a_s0), .S1(a_s1), .S2(a_s2), .bus(bus_a)
  );

  mux_scan_sequencer #(.SETTLE(SB), .DESCEND(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .mux_o(mux_b),
    .S0(b_s0), .S1(b_s1), .S2(b_s2), .bus(bus_b)
  );

  assign mux_a = pat_a[{a_s2, a_s1, a_s0}];
  assign mux_b = pat_b[{b_s2, b_s1, b_s0}];

  int n_cmp = 0;
  int n_bad = 0;
  int pops [2];

  // Reference model: per scan, only "edges since start was accepted".
  bit         m_active [2];
  bit         m_hold   [2];
  int         m_t      [2];
  logic [2:0] m_sel    [2];
  logic [7:0] m_last   [2];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  function automatic int settle_of(input int k);
    return (k == 0) ? SA : SB;
  endfunction

  function automatic logic [2:0] code_at(input int k, input int t);
    int p;
    p = t / (settle_of(k) + 1);
    return (k == 0) ? 3'(p) : 3'(7 - p);
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic model_step(input int k, input bit st, input bit rd, output bit push);
    push = 1'b0;
    if (m_active[k]) begin
      m_t[k]++;
      if (m_t[k] == 8 * (settle_of(k) + 1)) begin
        m_active[k] = 1'b0;
        m_hold[k]   = 1'b1;
        m_sel[k]    = code_at(k, m_t[k] - 1);
      end
    end else if (m_hold[k]) begin
      if (rd) m_hold[k] = 1'b0;
    end else if (st) begin
      m_active[k] = 1'b1;
      m_t[k]      = 0;
      push        = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit push;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_active[k] = 1'b0;
        m_hold[k]   = 1'b0;
        m_t[k]      = 0;
        m_sel[k]    = 3'd0;
        m_last[k]   = 8'h00;
      end
      exp_a.delete();
      exp_b.delete();
    end else begin
      model_step(0, bus_a.start, bus_a.ready, push);
      if (push) exp_a.push_back(pat_a);
      model_step(1, bus_b.start, bus_b.ready, push);
      if (push) exp_b.push_back(pat_b);
    end
  end

  task automatic check_core(input int k, input logic busy, input logic valid,
                            input logic [7:0] data, input logic [2:0] sel);
    logic [2:0] exp_sel;
    chk("busy", k, int'(busy), int'(m_active[k] || m_hold[k]));
    chk("valid", k, int'(valid), int'(m_hold[k]));
    exp_sel = m_active[k] ? code_at(k, m_t[k]) : m_sel[k];
    chk("sel", k, int'(sel), int'(exp_sel));
    if (!m_active[k] && !m_hold[k]) chk("idle_data", k, int'(data), int'(m_last[k]));
  endtask

  // Monitor: compares state every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    check_core(0, bus_a.busy, bus_a.valid, bus_a.data, {a_s2, a_s1, a_s0});
    check_core(1, bus_b.busy, bus_b.valid, bus_b.data, {b_s2, b_s1, b_s0});
    if (bus_a.valid) begin
      if (exp_a.size() == 0) chk("sb_empty", 0, 1, 0);
      else begin
        chk("sb_data", 0, int'(bus_a.data), int'(exp_a[0]));
        if (bus_a.ready) begin
          m_last[0] = exp_a.pop_front();
          pops[0]++;
        end
      end
    end
    if (bus_b.valid) begin
      if (exp_b.size() == 0) chk("sb_empty", 1, 1, 0);
      else begin
        chk("sb_data", 1, int'(bus_b.data), int'(exp_b[0]));
        if (bus_b.ready) begin
          m_last[1] = exp_b.pop_front();
          pops[1]++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_all(input bit st, input bit rd);
    bus_a.start = st; bus_b.start = st;
    bus_a.ready = rd; bus_b.ready = rd;
  endtask

  initial begin
    pops[0] = 0;
    pops[1] = 0;
    rst_n = 1'b0;
    set_all(1'b0, 1'b0);
    pat_a = 8'hA5;
    pat_b = 8'h3C;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Single-pulse scans with fixed patterns; valid then held with ready low.
    set_all(1'b1, 1'b0);
    tick(1);
    set_all(1'b0, 1'b0);
    tick(24);
    set_all(1'b0, 1'b1);
    tick(1);
    set_all(1'b0, 1'b0);
    tick(3);

    // start held high, ready tied high: back-to-back scans.
    pat_a = 8'($urandom);
    pat_b = 8'($urandom);
    set_all(1'b1, 1'b1);
    tick(60);
    set_all(1'b0, 1'b1);
    tick(20);

    // Random start/ready; patterns only change while no scan is in flight.
    for (int i = 0; i < 500; i++) begin
      bus_a.start = ($urandom_range(0, 3) == 0);
      bus_b.start = ($urandom_range(0, 3) == 0);
      bus_a.ready = 1'($urandom);
      bus_b.ready = 1'($urandom);
      if (!m_active[0]) pat_a = 8'($urandom);
      if (!m_active[1]) pat_b = 8'($urandom);
      tick(1);
    end
    set_all(1'b0, 1'b1);
    tick(20);

    // Abort mid-scan while dut0 is on code 3.
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    tick(6);
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 0, int'({a_s2, a_s1, a_s0}), 0);
    chk("rst_busy", 0, int'(bus_a.busy), 0);
    chk("rst_valid", 0, int'(bus_a.valid), 0);
    chk("rst_data", 0, int'(bus_a.data), 0);
    chk("rst_data", 1, int'(bus_b.data), 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    pat_a = 8'h5A;
    bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    tick(25);

    chk("pops_seen", 0, int'(pops[0] >= 5), 1);
    chk("pops_seen", 1, int'(pops[1] >= 5), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
